// File: rtl/knn_mem_pkg.sv
// Shared definitions for the KNN memory path: default sizes, response encoding
// and the bus address decode used by both the responder and the controller.
package knn_mem_pkg;

    localparam int DEF_W            = 32;
    localparam int DEF_DEPTH        = 1024;
    localparam int DEF_READ_LATENCY = 2;

    typedef enum logic {
        RESP_OK  = 1'b0,
        RESP_ERR = 1'b1
    } resp_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] idx;
    } dec_t;

    // Word stride equals W, so the index is a plain shift by log2(W).
    function automatic dec_t addr_decode(
        input logic [63:0] addr,
        input logic [63:0] base,
        input int unsigned shift,
        input int unsigned depth
    );
        dec_t        dec;
        logic [63:0] off;
        off       = addr - base;
        dec.valid = (addr >= base)
                    && ((off & ((64'd1 << shift) - 64'd1)) == 64'd0)
                    && ((off >> shift) < 64'(depth));
        dec.idx   = 32'(off >> shift);
        return dec;
    endfunction

endpackage

// File: rtl/knn_mem_read_pipe.sv
// Fixed-latency read pipeline; the last stage doubles as the held readdata
// register and only updates when a request completes.
module knn_mem_read_pipe #(
    parameter int W = 32,
    parameter int L = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic         in_err,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic         out_err,
    output logic [W-1:0] out_data
);

    logic [L-1:0] vld;
    logic [L-1:0] ers;
    logic [W-1:0] dat [L];

    always_ff @(posedge clk) begin
        if (!rst) begin
            vld        <= '0;
            ers        <= '0;
            dat[L-1]   <= '0;
        end else begin
            for (int k = L - 1; k > 0; k--) begin
                vld[k] <= vld[k-1];
                ers[k] <= ers[k-1];
                if (k < L - 1 || vld[k-1])
                    dat[k] <= dat[k-1];
            end
            vld[0] <= in_valid;
            ers[0] <= in_valid & in_err;
            // Errored reads carry zero so the output stage needs no extra mux.
            if (L > 1 || in_valid)
                dat[0] <= in_err ? '0 : in_data;
        end
    end

    assign out_valid = vld[L-1];
    assign out_err   = ers[L-1];
    assign out_data  = dat[L-1];

endmodule

// File: rtl/knn_mem_responder.sv
// On-chip RAM responder for the KNN memory controller bus with host preload
// port, fixed-latency reads and a saturating bus-write counter.
module knn_mem_responder
    import knn_mem_pkg::*;
#(
    parameter int              W            = DEF_W,
    parameter int              ADDR_W       = 32,
    parameter int              DEPTH        = DEF_DEPTH,
    parameter longint unsigned BASE_ADDR    = 0,
    parameter int              READ_LATENCY = DEF_READ_LATENCY,
    parameter int              CNT_W        = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     read,
    input  logic [ADDR_W-1:0]        readaddress,
    output logic [W-1:0]             readdata,
    output logic                     readvalid,
    input  logic                     write,
    input  logic [ADDR_W-1:0]        writeaddress,
    input  logic [W-1:0]             writedata,
    input  logic                     load_en,
    input  logic [$clog2(DEPTH)-1:0] load_idx,
    input  logic [W-1:0]             load_data,
    output logic                     load_ready,
    output logic                     err,
    output logic [CNT_W-1:0]         write_cnt
);

    localparam int          IDX_W = $clog2(DEPTH);
    localparam int unsigned SHIFT = $clog2(W);

    logic [W-1:0]     mem [DEPTH];
    dec_t             rdec;
    dec_t             wdec;
    logic [IDX_W-1:0] ridx;
    logic [IDX_W-1:0] widx;
    resp_e            rresp;
    logic             wr_ok;
    logic             ld_fire;
    logic             ld_ok;
    logic [W-1:0]     rd_word;
    logic             rd_err;
    logic             acc_err_q;

    always_comb begin
        rdec    = addr_decode(64'(readaddress), 64'(BASE_ADDR), SHIFT, DEPTH);
        wdec    = addr_decode(64'(writeaddress), 64'(BASE_ADDR), SHIFT, DEPTH);
        ridx    = IDX_W'(rdec.idx);
        widx    = IDX_W'(wdec.idx);
        rresp   = rdec.valid ? RESP_OK : RESP_ERR;
        wr_ok   = write & wdec.valid;
        ld_fire = load_en & load_ready;
        ld_ok   = ld_fire & (32'(load_idx) < 32'(DEPTH));
    end

    assign load_ready = ~write;

    // Single write port: bus write wins, preload only when the bus is idle.
    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[widx] <= writedata;
        else if (ld_ok)
            mem[load_idx] <= load_data;
    end

    // Write-first bypass for a read hitting the index written on the same edge.
    always_comb begin
        rd_word = mem[ridx];
        if (wr_ok && widx == ridx)
            rd_word = writedata;
        else if (ld_ok && load_idx == ridx)
            rd_word = load_data;
    end

    knn_mem_read_pipe #(
        .W (W),
        .L (READ_LATENCY)
    ) u_read_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (read),
        .in_err    (rresp == RESP_ERR),
        .in_data   (rd_word),
        .out_valid (readvalid),
        .out_err   (rd_err),
        .out_data  (readdata)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_err_q <= 1'b0;
            write_cnt <= '0;
        end else begin
            acc_err_q <= (write & ~wdec.valid) | (ld_fire & ~ld_ok);
            if (wr_ok && write_cnt != '1)
                write_cnt <= write_cnt + 1'b1;
        end
    end

    assign err = rd_err | acc_err_q;

endmodule

// File: tb/tb_knn_mem_responder.sv
// Directed bench for knn_mem_responder: preload, pipelined reads, writes,
// error decode, load arbitration, counter saturation and in-flight reset.
module tb_knn_mem_responder;

    localparam int              W     = 32;
    localparam int              AW    = 32;
    localparam int              DEPTH = 12;
    localparam longint unsigned BASE  = 64'h100;
    localparam int              CW    = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          read = 1'b0;
    logic [AW-1:0] readaddress = '0;
    logic [W-1:0]  readdata;
    logic          readvalid;
    logic          write = 1'b0;
    logic [AW-1:0] writeaddress = '0;
    logic [W-1:0]  writedata = '0;
    logic          load_en = 1'b0;
    logic [3:0]    load_idx = '0;
    logic [W-1:0]  load_data = '0;
    logic          load_ready;
    logic          err;
    logic [CW-1:0] write_cnt;

    int checks = 0;
    int errors = 0;

    knn_mem_responder #(
        .W(W), .ADDR_W(AW), .DEPTH(DEPTH), .BASE_ADDR(BASE),
        .READ_LATENCY(2), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .read(read), .readaddress(readaddress), .readdata(readdata), .readvalid(readvalid),
        .write(write), .writeaddress(writeaddress), .writedata(writedata),
        .load_en(load_en), .load_idx(load_idx), .load_data(load_data), .load_ready(load_ready),
        .err(err), .write_cnt(write_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [AW-1:0] waddr(input int idx);
        return AW'(BASE + 64'(idx * W));
    endfunction

    // Issues one read and returns outputs sampled right after completion.
    task automatic rd(input logic [AW-1:0] a, output logic [W-1:0] d,
                      output logic v, output logic e);
        read = 1'b1;
        readaddress = a;
        tick();
        read = 1'b0;
        tick();
        d = readdata;
        v = readvalid;
        e = err;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        checks++;
        if (readdata !== 32'd0 || readvalid !== 1'b0 || err !== 1'b0 || write_cnt !== 4'd0) begin
            errors++;
            $display("FAIL reset_state: rd=%h rv=%b err=%b cnt=%0d want 0/0/0/0",
                     readdata, readvalid, err, write_cnt);
        end
        checks++;
        if (load_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_load_ready: got %b want 1", load_ready);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_preload_read();
        load_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            load_idx = 4'(i);
            load_data = 32'(10 + i);
            tick();
        end
        load_idx = 4'd6;
        load_data = 32'h60;
        tick();
        load_en = 1'b0;
        read = 1'b1;
        readaddress = waddr(2);
        tick();
        read = 1'b0;
        checks++;
        if (readvalid !== 1'b0) begin
            errors++;
            $display("FAIL latency_early: rv=%b want 0 one cycle after read", readvalid);
        end
        tick();
        checks++;
        if (readvalid !== 1'b1 || readdata !== 32'd12 || err !== 1'b0) begin
            errors++;
            $display("FAIL read_idx2: rv=%b rd=%0d err=%b want 1/12/0", readvalid, readdata, err);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (readvalid !== 1'b0 || readdata !== 32'd12) begin
                errors++;
                $display("FAIL read_hold: cyc %0d rv=%b rd=%0d want 0/12", i, readvalid, readdata);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            read = (i < 4);
            readaddress = waddr(i < 4 ? i : 0);
            tick();
            checks++;
            if (i >= 1 && i <= 4) begin
                if (readvalid !== 1'b1 || readdata !== 32'(10 + i - 1)) begin
                    errors++;
                    $display("FAIL b2b: edge %0d rv=%b rd=%0d want 1/%0d", i, readvalid, readdata, 10 + i - 1);
                end
            end else if (readvalid !== 1'b0) begin
                errors++;
                $display("FAIL b2b_idle: edge %0d rv=%b want 0", i, readvalid);
            end
        end
        read = 1'b0;
    endtask

    task automatic test_write();
        logic [W-1:0] d;
        logic v, e;
        write = 1'b1;
        writeaddress = waddr(7);
        writedata = 32'h5;
        tick();
        write = 1'b0;
        checks++;
        if (write_cnt !== 4'd1 || err !== 1'b0) begin
            errors++;
            $display("FAIL write_cnt1: cnt=%0d err=%b want 1/0", write_cnt, err);
        end
        rd(waddr(7), d, v, e);
        checks++;
        if (v !== 1'b1 || d !== 32'h5) begin
            errors++;
            $display("FAIL write_readback: rv=%b rd=%h want 1/5", v, d);
        end
        write = 1'b1;
        writedata = 32'h9;
        read = 1'b1;
        readaddress = waddr(7);
        tick();
        write = 1'b0;
        read = 1'b0;
        tick();
        checks++;
        if (readvalid !== 1'b1 || readdata !== 32'h9 || write_cnt !== 4'd2) begin
            errors++;
            $display("FAIL write_first: rv=%b rd=%h cnt=%0d want 1/9/2", readvalid, readdata, write_cnt);
        end
    endtask

    task automatic test_errors();
        logic [W-1:0] d;
        logic v, e;
        rd(waddr(0) + 32'd1, d, v, e);
        checks++;
        if (v !== 1'b1 || e !== 1'b1 || d !== 32'd0) begin
            errors++;
            $display("FAIL misaligned_read: rv=%b err=%b rd=%h want 1/1/0", v, e, d);
        end
        rd(waddr(DEPTH), d, v, e);
        checks++;
        if (v !== 1'b1 || e !== 1'b1 || d !== 32'd0) begin
            errors++;
            $display("FAIL oob_read: rv=%b err=%b rd=%h want 1/1/0", v, e, d);
        end
        rd(AW'(BASE - 64'(W)), d, v, e);
        checks++;
        if (v !== 1'b1 || e !== 1'b1 || d !== 32'd0) begin
            errors++;
            $display("FAIL below_base_read: rv=%b err=%b rd=%h want 1/1/0", v, e, d);
        end
        tick();
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_single_pulse: err=%b want 0", err);
        end
        write = 1'b1;
        writeaddress = waddr(DEPTH);
        writedata = 32'hDEAD;
        tick();
        write = 1'b0;
        checks++;
        if (err !== 1'b1 || write_cnt !== 4'd2) begin
            errors++;
            $display("FAIL oob_write: err=%b cnt=%0d want 1/2", err, write_cnt);
        end
        tick();
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL oob_write_pulse: err=%b want 0", err);
        end
        rd(waddr(0), d, v, e);
        checks++;
        if (v !== 1'b1 || d !== 32'd10 || e !== 1'b0) begin
            errors++;
            $display("FAIL oob_write_mem: rv=%b rd=%0d err=%b want 1/10/0", v, d, e);
        end
        load_en = 1'b1;
        load_idx = 4'd13;
        load_data = 32'hBAD;
        tick();
        load_en = 1'b0;
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL oob_load: err=%b want 1", err);
        end
        tick();
    endtask

    task automatic test_load_priority();
        logic [W-1:0] d;
        logic v, e;
        write = 1'b1;
        writeaddress = waddr(5);
        writedata = 32'h55;
        load_en = 1'b1;
        load_idx = 4'd6;
        load_data = 32'h66;
        #1;
        checks++;
        if (load_ready !== 1'b0) begin
            errors++;
            $display("FAIL load_ready_busy: got %b want 0", load_ready);
        end
        tick();
        write = 1'b0;
        load_en = 1'b0;
        #1;
        checks++;
        if (load_ready !== 1'b1) begin
            errors++;
            $display("FAIL load_ready_idle: got %b want 1", load_ready);
        end
        rd(waddr(6), d, v, e);
        checks++;
        if (d !== 32'h60) begin
            errors++;
            $display("FAIL load_blocked: rd=%h want 60", d);
        end
        rd(waddr(5), d, v, e);
        checks++;
        if (d !== 32'h55 || write_cnt !== 4'd3) begin
            errors++;
            $display("FAIL write_over_load: rd=%h cnt=%0d want 55/3", d, write_cnt);
        end
        load_en = 1'b1;
        tick();
        load_en = 1'b0;
        rd(waddr(6), d, v, e);
        checks++;
        if (d !== 32'h66) begin
            errors++;
            $display("FAIL load_applied: rd=%h want 66", d);
        end
        load_en = 1'b1;
        load_idx = 4'd9;
        load_data = 32'h99;
        read = 1'b1;
        readaddress = waddr(9);
        tick();
        load_en = 1'b0;
        read = 1'b0;
        tick();
        checks++;
        if (readvalid !== 1'b1 || readdata !== 32'h99) begin
            errors++;
            $display("FAIL load_write_first: rv=%b rd=%h want 1/99", readvalid, readdata);
        end
    endtask

    task automatic test_saturation();
        write = 1'b1;
        writeaddress = waddr(8);
        for (int i = 0; i < 12; i++) begin
            writedata = 32'(i);
            tick();
        end
        checks++;
        if (write_cnt !== 4'd15) begin
            errors++;
            $display("FAIL cnt_reach_max: cnt=%0d want 15", write_cnt);
        end
        tick();
        tick();
        write = 1'b0;
        checks++;
        if (write_cnt !== 4'd15) begin
            errors++;
            $display("FAIL cnt_saturate: cnt=%0d want 15", write_cnt);
        end
    endtask

    task automatic test_reset_inflight();
        logic [W-1:0] d;
        logic v, e;
        read = 1'b1;
        readaddress = waddr(2);
        tick();
        read = 1'b0;
        rst = 1'b0;
        tick();
        checks++;
        if (readvalid !== 1'b0 || readdata !== 32'd0 || write_cnt !== 4'd0) begin
            errors++;
            $display("FAIL reset_inflight: rv=%b rd=%h cnt=%0d want 0/0/0", readvalid, readdata, write_cnt);
        end
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (readvalid !== 1'b0) begin
                errors++;
                $display("FAIL reset_dropped: cyc %0d rv=%b want 0", i, readvalid);
            end
        end
        rd(waddr(2), d, v, e);
        checks++;
        if (v !== 1'b1 || d !== 32'd12) begin
            errors++;
            $display("FAIL mem_survives_reset: rv=%b rd=%0d want 1/12", v, d);
        end
        rd(waddr(7), d, v, e);
        checks++;
        if (d !== 32'h9) begin
            errors++;
            $display("FAIL mem_survives_reset7: rd=%h want 9", d);
        end
    endtask

    initial begin
        test_reset();
        test_preload_read();
        test_back_to_back();
        test_write();
        test_errors();
        test_load_priority();
        test_saturation();
        test_reset_inflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
